// File: rtl/uart_msg_tx.sv
// Message-oriented UART transmitter: fetches msg_len characters from an external
// character source and serialises each as a start/data/parity/stop frame.
module uart_msg_tx #(
   parameter int unsigned CLKS_PER_BIT = 10417,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] msg_len,
   input  logic                  loop,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_BITS-1:0]  rd_data,
   output logic                  TxD,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_MAX = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PAR, STOP} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_q, par_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  rd_en_q, rd_en_d;
   logic                  bit_end_c;

   assign bit_end_c = (cnt_q == CNT_MAX);

   // Next-state and next-output logic; outputs are derived from the next state
   // so every output leaves a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      len_d   = len_q;
      addr_d  = addr_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (msg_len != '0)) begin
               len_d   = msg_len;
               addr_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = rd_data;
            par_d   = (PARITY == 2) ? ~(^rd_data) : (^rd_data);
            cnt_d   = '0;
            state_d = START;
         end
         START: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_MAX) begin
                  stop_d  = 1'b0;
                  state_d = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PAR: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               stop_d  = 1'b0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               cnt_d = '0;
               if (stop_q == STOP_MAX) begin
                  // loop is only consulted once the final character has gone out
                  if (addr_q < (len_q - ADDR_WIDTH'(1))) begin
                     addr_d  = addr_q + ADDR_WIDTH'(1);
                     state_d = FETCH;
                  end else if (loop) begin
                     addr_d  = '0;
                     state_d = FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      rd_en_d = (state_d == FETCH);
      busy_d  = (state_d != IDLE);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PAR:     txd_d = par_d;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         len_q   <= '0;
         addr_q  <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
      end
   end

   assign rd_en   = rd_en_q;
   assign rd_addr = addr_q;
   assign TxD     = txd_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Scoreboard bench for uart_msg_tx: three parameter sets, expected characters
// queued at stimulus time, a serial/fetch/done monitor compares against a frame model.
module tb_uart_msg_tx;

   localparam int NC  = 3;
   localparam int CPB = 4;
   localparam int AW  = 4;
   localparam int DB_C   [NC] = '{8, 8, 7};
   localparam int PAR_C  [NC] = '{0, 1, 2};
   localparam int STOP_C [NC] = '{1, 1, 2};

   typedef struct {
      int         k;
      int         addr;
      logic [7:0] data;
      bit         first;
      bit         last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_a   [NC];
   logic          loop_a    [NC];
   logic [AW-1:0] msg_len_a [NC];
   logic          rd_en_a   [NC];
   logic [AW-1:0] rd_addr_a [NC];
   logic [7:0]    rd_data_a [NC];
   logic          txd_a     [NC];
   logic          busy_a    [NC];
   logic          done_a    [NC];
   logic [7:0]    rom       [16];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t  exp_q [$];
   string sp_name [$];
   int    sp_k [$];
   int    sp_got [$];
   int    sp_exp [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      uart_msg_tx #(
         .CLKS_PER_BIT(CPB), .DATA_BITS(DB_C[g]), .PARITY(PAR_C[g]),
         .STOP_BITS(STOP_C[g]), .ADDR_WIDTH(AW)
      ) u_dut (
         .clk     (clk),
         .rst     (rst_n),
         .start   (start_a[g]),
         .msg_len (msg_len_a[g]),
         .loop    (loop_a[g]),
         .rd_en   (rd_en_a[g]),
         .rd_addr (rd_addr_a[g]),
         .rd_data (rd_data_a[g][DB_C[g]-1:0]),
         .TxD     (txd_a[g]),
         .busy    (busy_a[g]),
         .done    (done_a[g])
      );
   end

   // Character source: data valid the cycle after the read strobe
   always @(posedge clk)
      for (int k = 0; k < NC; k++)
         if (rd_en_a[k]) rd_data_a[k] <= rom[rd_addr_a[k]];

   function automatic int flen(int k);
      return (1 + DB_C[k] + ((PAR_C[k] != 0) ? 1 : 0) + STOP_C[k]) * CPB;
   endfunction

   // Expected TxD level for each cycle of a frame carrying character d
   function automatic logic [63:0] fbits(int k, logic [7:0] d);
      logic [63:0] v;
      logic        p;
      int          b;
      v = '0;
      p = 1'b0;
      for (int i = 0; i < DB_C[k]; i++) p = p ^ d[i];
      if (PAR_C[k] == 2) p = ~p;
      for (int i = 0; i < flen(k); i++) begin
         b = i / CPB;
         if (b == 0)                                v[i] = 1'b0;
         else if (b <= DB_C[k])                     v[i] = d[b-1];
         else if (PAR_C[k] != 0 && b == DB_C[k] + 1) v[i] = p;
         else                                       v[i] = 1'b1;
      end
      return v;
   endfunction

   task automatic chk(string nm, int k, int g, int e);
      checks++;
      if (g != e) begin
         errors++;
         $display("FAIL %s cfg%0d: got %0d, expected %0d", nm, k, g, e);
      end
   endtask

   // ---------------- monitor ----------------
   int          in_fr  [NC];
   int          pos    [NC];
   int          fend   [NC];
   int          rd_cnt [NC];
   int          rd_cyc [NC];
   int          rd_adr [NC];
   int          due    [NC];
   int          brise  [NC];
   logic        bprev  [NC];
   logic        blow   [NC];
   logic [63:0] got    [NC];
   logic [63:0] want;
   exp_t        cur    [NC];

   always @(negedge clk) begin
      while (sp_name.size() > 0)
         chk(sp_name.pop_front(), sp_k.pop_front(), sp_got.pop_front(), sp_exp.pop_front());
      for (int k = 0; k < NC; k++) begin
         if (!rst_n) begin
            in_fr[k]  = 0;
            rd_cnt[k] = 0;
            due[k]    = -1;
            bprev[k]  = 1'b0;
            brise[k]  = -100;
            fend[k]   = -100;
         end else begin
            if (busy_a[k] && !bprev[k]) begin
               chk("busy_rise_expected", k,
                   (exp_q.size() > 0 && exp_q[0].k == k && exp_q[0].first) ? 1 : 0, 1);
               brise[k] = cyc;
            end
            bprev[k] = busy_a[k];
            if (rd_en_a[k]) begin
               rd_cnt[k]++;
               rd_cyc[k] = cyc;
               rd_adr[k] = int'(rd_addr_a[k]);
               if (done_a[k]) chk("done_with_rd_en", k, 1, 0);
            end
            if (due[k] == cyc) begin
               chk("done_pulse", k, int'(done_a[k]), 1);
               chk("idle_after_done", k, int'(busy_a[k]), 0);
               due[k] = -1;
            end else if (done_a[k]) begin
               chk("spurious_done", k, 1, 0);
            end
            if (in_fr[k] != 0) begin
               got[k][pos[k]] = txd_a[k];
               if (!busy_a[k]) blow[k] = 1'b1;
               pos[k]++;
               if (pos[k] == flen(k)) begin
                  want = fbits(k, cur[k].data);
                  checks++;
                  if (got[k] != want) begin
                     errors++;
                     $display("FAIL frame cfg%0d addr%0d: got %h, expected %h",
                              k, cur[k].addr, got[k], want);
                  end
                  chk("busy_in_frame", k, int'(blow[k]), 0);
                  in_fr[k] = 0;
                  fend[k]  = cyc;
                  if (cur[k].last) due[k] = cyc + 1;
               end
            end else if (!txd_a[k]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", k, 1, 0);
                  cur[k].k = -1; cur[k].addr = -1; cur[k].data = 8'h00;
                  cur[k].first = 1'b0; cur[k].last = 1'b0;
               end else begin
                  cur[k] = exp_q.pop_front();
               end
               chk("frame_owner", k, cur[k].k, k);
               chk("fetch_count", k, rd_cnt[k], 1);
               chk("fetch_addr", k, rd_adr[k], cur[k].addr);
               chk("fetch_lead", k, cyc - rd_cyc[k], 2);
               if (cur[k].first) chk("busy_lead", k, cyc - brise[k], 2);
               else              chk("char_gap", k, cyc - fend[k] - 1, 2);
               rd_cnt[k] = 0;
               got[k]    = '0;
               pos[k]    = 1;
               blow[k]   = !busy_a[k];
               in_fr[k]  = 1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic spot(string nm, int k, int g, int e);
      sp_name.push_back(nm);
      sp_k.push_back(k);
      sp_got.push_back(g);
      sp_exp.push_back(e);
   endtask

   task automatic push_msg(int k, int len, int iters);
      exp_t e;
      for (int it = 0; it < iters; it++)
         for (int a = 0; a < len; a++) begin
            e.k     = k;
            e.addr  = a;
            e.data  = rom[a];
            e.first = (it == 0 && a == 0);
            e.last  = (it == iters - 1 && a == len - 1);
            exp_q.push_back(e);
         end
   endtask

   task automatic pulse_start(int k, int len);
      @(negedge clk);
      start_a[k]   = 1'b1;
      msg_len_a[k] = AW'(len);
      @(negedge clk);
      start_a[k]   = 1'b0;
   endtask

   task automatic wait_idle(int k, int budget);
      int n;
      n = 0;
      while (busy_a[k] && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy_a[k]) spot("idle_timeout", k, 1, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic send(int k, int len);
      push_msg(k, len, 1);
      pulse_start(k, len);
      wait_idle(k, len * (flen(k) + 2) + 20);
   endtask

   task automatic rand_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int n;
      int len;
      rst_n = 1'b0;
      for (int k = 0; k < NC; k++) begin
         start_a[k]   = 1'b0;
         loop_a[k]    = 1'b0;
         msg_len_a[k] = '0;
      end
      rand_rom();
      repeat (3) @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         spot("reset_txd", k, int'(txd_a[k]), 1);
         spot("reset_busy", k, int'(busy_a[k]), 0);
         spot("reset_done", k, int'(done_a[k]), 0);
         spot("reset_rd_en", k, int'(rd_en_a[k]), 0);
         spot("reset_rd_addr", k, int'(rd_addr_a[k]), 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single character 'A' on every parameter set
      rom[0] = 8'h41;
      for (int k = 0; k < NC; k++) send(k, 1);

      // three-character message
      rom[0] = 8'h41; rom[1] = 8'h42; rom[2] = 8'h43;
      send(0, 3);

      // zero-length start is ignored
      pulse_start(0, 0);
      repeat (30) @(negedge clk);
      spot("len0_busy", 0, int'(busy_a[0]), 0);

      // looping two-character message; loop dropped mid-way through an addr-0 frame
      rand_rom();
      push_msg(0, 2, 4);
      loop_a[0] = 1'b1;
      pulse_start(0, 2);
      repeat (273) @(negedge clk);
      loop_a[0] = 1'b0;
      wait_idle(0, 400);

      // asynchronous reset during data bit 3
      rom[0] = 8'h41;
      push_msg(0, 1, 1);
      pulse_start(0, 1);
      n = 0;
      while (txd_a[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (17) @(negedge clk);
      #2;
      spot("pre_rst_txd", 0, int'(txd_a[0]), 0);
      rst_n = 1'b0;
      #1;
      spot("rst_txd", 0, int'(txd_a[0]), 1);
      spot("rst_busy", 0, int'(busy_a[0]), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rand_rom();
      send(0, 2);

      // randomized messages, some with start/msg_len disturbance while busy
      for (int it = 0; it < 12; it++) begin
         int k;
         k   = it % NC;
         len = $urandom_range(1, 4);
         rand_rom();
         push_msg(k, len, 1);
         pulse_start(k, len);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            if (busy_a[k]) begin
               start_a[k]   = 1'b1;
               msg_len_a[k] = AW'($urandom_range(0, 15));
               @(negedge clk);
               start_a[k]   = 1'b0;
            end
         end
         wait_idle(k, len * (flen(k) + 2) + 40);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end

      spot("leftover_expected", -1, exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
